tag_scrub_writer: RTL and testbench
===================================

Name: tag_scrub_writer

Overview:
- Write-side controller directly upstream of the tag-indexed store: 16 one-bit security tags (0=L, 1=H), each governing one 3-bit data entry.
- Accepts write and retag requests over a valid/ready handshake and serialises them into single-entry array write strobes.
- On any H->L downgrade, the block scrubs (zeroes) the entry while it is still tagged H, then writes the new tag, so H data is never visible under an L tag.
- Holds an authoritative shadow copy of all tags; it is the only writer of tags and data.

Parameters:
- DEPTH, 16, number of entries
- IDX_W, 4, index width; DEPTH must equal 2**IDX_W
- DATA_W, 3, data entry width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_retag  in  1  1 = change tag of req_idx to req_tag; 0 = data write
- req_idx  in  IDX_W  target entry
- req_tag  in  1  new tag (retag only)
- req_data  in  DATA_W  write data (data write only)
- req_sec  in  1  security level of req_data (0=L, 1=H)
- wr_en  out  1  data write strobe to array
- wr_idx  out  IDX_W  data/tag write index
- wr_data  out  DATA_W  data to write
- tag_wr_en  out  1  tag write strobe to array
- tag_wr_val  out  1  tag value to write
- tags_q  out  DEPTH  shadow tag vector, bit i = tag of entry i
- err  out  1  one-cycle pulse: rejected request
- busy  out  1  FSM not in IDLE

Behaviour:
- All outputs are registered. Request/response latency: accept at cycle N, strobe(s) at N+1 (and N+2 for a scrub).
- Reset (sync, any state, including mid-scrub):
  - FSM -> IDLE; tags_q=0.
  - wr_en=0, tag_wr_en=0, err=0, busy=0, wr_idx=0, wr_data=0, tag_wr_val=0.
  - req_ready=1 from the first cycle after reset deasserts (see the optional feature).
- Handshake: a request is accepted when req_valid and req_ready are both high. req_ready=1 only in IDLE. The block captures idx/data/tag/sec on acceptance. The requester must hold the request until it is accepted.
- FSM states: IDLE, WRITE, SCRUB, RETAG.
- IDLE, data request (req_retag=0):
  - If req_sec=1 and tags_q[idx]=0: reject. Raise err for 1 cycle, no strobes, stay IDLE.
  - Otherwise go to WRITE.
- IDLE, retag request:
  - Old tag 1, new tag 0: go to SCRUB.
  - Old tag 0, new tag 1: go to RETAG.
  - New tag equals old tag: no-op. No strobe, no err, stay IDLE.
- WRITE (1 cycle): wr_en=1, wr_idx=idx, wr_data=data. Then IDLE.
- SCRUB (1 cycle): wr_en=1, wr_data=0, tags_q unchanged (entry still H). Then RETAG.
- RETAG (1 cycle): tag_wr_en=1, tag_wr_val=new tag; tags_q[idx] updated at the end of this cycle. Then IDLE.
- Strobe timing:
  - wr_en and tag_wr_en are never high in the same cycle.
  - Strobes are single-cycle pulses. When not strobing, wr_data is 0.
- Back-to-back throughput:
  - IDLE->WRITE->IDLE gives 1 request per 2 cycles.
  - A downgrade takes 3 cycles.
- Index wrap: indices are exactly IDX_W bits; no out-of-range case exists.
- busy=1 in WRITE, SCRUB, RETAG (and SWEEP if compiled in).

Optional Feature:
- Macro: TAG_SCRUB_SWEEP_EN.
- With the macro: reset enters state SWEEP instead of IDLE. A 4-bit counter walks entries 0..DEPTH-1, one per cycle, issuing wr_en=1, wr_data=0, wr_idx=count. req_ready=0 and busy=1 throughout. After entry DEPTH-1 the block enters IDLE, so the first request is accepted DEPTH+1 cycles after reset deasserts. Reset asserted mid-sweep restarts the sweep from 0.
- Without the macro: there is no SWEEP state and no counter; the block enters IDLE directly after reset.

Test Plan:
- Reset, then request idx=3, data=5, sec=0 -> next cycle wr_en=1, wr_idx=3, wr_data=5; tags_q=0x0000; err=0.
- Retag idx=7 to H -> one cycle with tag_wr_en=1, tag_wr_val=1, tags_q=0x0080. Then data idx=7, data=6, sec=1 -> wr_en=1, wr_data=6.
- With entry 7 tagged H, retag it to L -> cycle 1: wr_en=1, wr_idx=7, wr_data=0, tag_wr_en=0; cycle 2: tag_wr_en=1, tag_wr_val=0; tags_q returns to 0x0000; busy=1 for both cycles.
- Data idx=2, sec=1 while tags_q[2]=0 -> err pulses 1 cycle, no strobes. Retag idx=2 to 0 -> no strobes, no err.
- Assert reset during SCRUB -> next cycle all strobes 0, tags_q=0, req_ready=1 (or SWEEP starts if TAG_SCRUB_SWEEP_EN).
- With TAG_SCRUB_SWEEP_EN: after reset, 16 consecutive wr_en pulses with wr_idx 0..15 and wr_data=0, req_ready=0 throughout; req_ready=1 on cycle 17.

Source files
------------

// File: rtl/tag_scrub_writer.sv
// Write-side controller for the 16-entry tagged store: serialises data writes and retags into array strobes,
// scrubbing an entry before any H->L downgrade. Optional power-up zeroing sweep: define TAG_SCRUB_SWEEP_EN.
module tag_scrub_writer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_retag,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic              req_tag,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_sec,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic              tag_wr_en,
  output logic              tag_wr_val,
  output logic [DEPTH-1:0]  tags_q,
  output logic              err,
  output logic              busy
);

  if (DEPTH != (1 << IDX_W)) begin : g_bad_depth
    $error("DEPTH must equal 2**IDX_W");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_SCRUB = 3'd2,
    S_RETAG = 3'd3
`ifdef TAG_SCRUB_SWEEP_EN
    , S_SWEEP = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic                tag_q, tag_n;
  logic                accept, reject, old_tag;
  logic                wr_en_d, tag_wr_en_d, tag_wr_val_d;
  logic [IDX_W-1:0]    wr_idx_d;
  logic [DATA_W-1:0]   wr_data_d;
`ifdef TAG_SCRUB_SWEEP_EN
  logic [IDX_W-1:0]    cnt_q, cnt_n;
  assign cnt_n = cnt_q + 1'b1;
`endif

  // Handshake: a request transfers on a cycle where req_valid && req_ready; req_ready is high
  // only in IDLE, and the requester holds all req_* fields stable until that transfer.
  assign accept  = req_valid && (state_q == S_IDLE);
  assign old_tag = tags_q[req_idx];
  assign idx_n   = accept ? req_idx  : idx_q;
  assign data_n  = accept ? req_data : data_q;
  assign tag_n   = accept ? req_tag  : tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef TAG_SCRUB_SWEEP_EN
      state_q <= S_SWEEP;
`else
      state_q <= S_IDLE;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reject  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!req_retag) begin
            // H data may only land in an entry already tagged H
            if (req_sec && !old_tag) reject  = 1'b1;
            else                     state_d = S_WRITE;
          end else if (old_tag && !req_tag) begin
            state_d = S_SCRUB;
          end else if (!old_tag && req_tag) begin
            state_d = S_RETAG;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_SCRUB: state_d = S_RETAG;
      S_RETAG: state_d = S_IDLE;
`ifdef TAG_SCRUB_SWEEP_EN
      S_SWEEP: if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so decode the state being entered rather than the current one.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_idx_d     = '0;
    wr_data_d    = '0;
    tag_wr_en_d  = 1'b0;
    tag_wr_val_d = 1'b0;
    case (state_d)
      S_WRITE: begin
        wr_en_d   = 1'b1;
        wr_idx_d  = idx_n;
        wr_data_d = data_n;
      end
      S_SCRUB: begin
        wr_en_d  = 1'b1;
        wr_idx_d = idx_n;
      end
      S_RETAG: begin
        tag_wr_en_d  = 1'b1;
        wr_idx_d     = idx_n;
        tag_wr_val_d = tag_n;
      end
`ifdef TAG_SCRUB_SWEEP_EN
      S_SWEEP: begin
        wr_en_d  = 1'b1;
        wr_idx_d = cnt_n;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      tag_q      <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      tag_wr_en  <= 1'b0;
      tag_wr_val <= 1'b0;
      err        <= 1'b0;
`ifdef TAG_SCRUB_SWEEP_EN
      // The sweep's first strobe (entry 0) is presented straight out of reset
      cnt_q      <= '0;
      wr_en      <= 1'b1;
      req_ready  <= 1'b0;
      busy       <= 1'b1;
`else
      wr_en      <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
`endif
    end else begin
      idx_q      <= idx_n;
      data_q     <= data_n;
      tag_q      <= tag_n;
      if (state_q == S_RETAG) tags_q[idx_q] <= tag_q;
      wr_en      <= wr_en_d;
      wr_idx     <= wr_idx_d;
      wr_data    <= wr_data_d;
      tag_wr_en  <= tag_wr_en_d;
      tag_wr_val <= tag_wr_val_d;
      err        <= reject;
      req_ready  <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
`ifdef TAG_SCRUB_SWEEP_EN
      cnt_q      <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_tag_scrub_writer.sv
// Bench for tag_scrub_writer: directed scenarios then random requests, each accepted request expanded by a
// reference model into the per-cycle strobe sequence it should produce. Follows TAG_SCRUB_SWEEP_EN if defined.
module tb_tag_scrub_writer;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_retag, req_tag, req_sec;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_data;
  logic              wr_en, tag_wr_en, tag_wr_val, err, busy;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DEPTH-1:0]  tags_q;

  always #5 clk = ~clk;

  tag_scrub_writer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_retag(req_retag),
    .req_idx(req_idx), .req_tag(req_tag), .req_data(req_data), .req_sec(req_sec),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .tag_wr_en(tag_wr_en), .tag_wr_val(tag_wr_val),
    .tags_q(tags_q), .err(err), .busy(busy)
  );

  typedef struct packed {
    logic              retag;
    logic [IDX_W-1:0]  idx;
    logic              tag;
    logic [DATA_W-1:0] data;
    logic              sec;
  } req_t;

  // What the block should show in one cycle
  typedef struct packed {
    logic              wr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              tag_en;
    logic              tag_val;
    logic              ready;
    logic              busy;
    logic              err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  logic [DEPTH-1:0] model_tags;
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic we, input logic [IDX_W-1:0] ix, input logic [DATA_W-1:0] dt,
                              input logic te, input logic tv, input logic rdy, input logic bsy, input logic er);
    exp_t e;
    e = '{wr_en: we, idx: ix, data: dt, tag_en: te, tag_val: tv, ready: rdy, busy: bsy, err: er};
    return e;
  endfunction

  function automatic req_t mkreq(input logic rt, input int ix, input logic tg, input int dt, input logic sc);
    req_t r;
    r = '{retag: rt, idx: IDX_W'(ix), tag: tg, data: DATA_W'(dt), sec: sc};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expand an accepted request into the cycles that must follow it
  task automatic predict(input req_t r);
    if (!r.retag) begin
      if (r.sec && !model_tags[r.idx]) exp_q.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      else exp_q.push_back(mk(1'b1, r.idx, r.data, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (model_tags[r.idx] != r.tag) begin
      if (!r.tag) exp_q.push_back(mk(1'b1, r.idx, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, r.idx, '0, 1'b1, r.tag, 1'b0, 1'b1, 1'b0));
    end
  endtask

  // One clock: check this cycle's outputs, then drive the inputs sampled at the coming edge
  task automatic step(input logic v, input req_t r, output logic acc);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() != 0) e = exp_t'(exp_q.pop_front());
    else                   e = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wr_en", 32'(wr_en), 32'(e.wr_en));
    check("tag_wr_en", 32'(tag_wr_en), 32'(e.tag_en));
    check("wr_data", 32'(wr_data), 32'(e.data));
    if (e.wr_en || e.tag_en || reset) check("wr_idx", 32'(wr_idx), 32'(e.idx));
    if (e.tag_en || reset) check("tag_wr_val", 32'(tag_wr_val), 32'(e.tag_val));
    check("req_ready", 32'(req_ready), 32'(e.ready));
    check("busy", 32'(busy), 32'(e.busy));
    check("err", 32'(err), 32'(e.err));
    check("tags_q", 32'(tags_q), 32'(model_tags));
    if (e.tag_en) model_tags[e.idx] = e.tag_val;
    reset     = 1'b0;
    req_valid = v;
    req_retag = r.retag;
    req_idx   = r.idx;
    req_tag   = r.tag;
    req_data  = r.data;
    req_sec   = r.sec;
    acc = v && e.ready;
    if (acc) predict(r);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    model_tags = '0;
`ifdef TAG_SCRUB_SWEEP_EN
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(mk(1'b1, IDX_W'(k), '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
`endif
    @(posedge clk);
  endtask

  task automatic issue(input req_t r);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      step(1'b1, r, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    req_t r;
    logic acc, hold;
    reset = 1'b1; req_valid = 1'b0; req_retag = 1'b0; req_idx = '0;
    req_tag = 1'b0; req_data = '0; req_sec = 1'b0;

    do_reset();
    idle(2);
    issue(mkreq(1'b0, 3, 1'b0, 5, 1'b0)); idle(2);   // plain L write
    issue(mkreq(1'b1, 7, 1'b1, 0, 1'b0)); idle(2);   // upgrade 7 to H
    issue(mkreq(1'b0, 7, 1'b0, 6, 1'b1)); idle(1);   // H write into H entry
    issue(mkreq(1'b1, 7, 1'b0, 0, 1'b0)); idle(3);   // downgrade: scrub then retag
    issue(mkreq(1'b0, 2, 1'b0, 4, 1'b1)); idle(1);   // H write into L entry rejected
    issue(mkreq(1'b1, 2, 1'b0, 0, 1'b0)); idle(1);   // same-tag retag is a no-op
    issue(mkreq(1'b1, 5, 1'b1, 0, 1'b0)); idle(2);
    issue(mkreq(1'b1, 5, 1'b0, 0, 1'b0)); idle(1);   // now in SCRUB
    do_reset();
    idle(3);

    hold = 1'b0;
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if (!hold && $urandom_range(0, 9) < 6) begin
        r = mkreq(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, (1 << DATA_W) - 1)), 1'($urandom_range(0, 1)));
        hold = 1'b1;
      end
      step(hold, r, acc);
      if (acc) hold = 1'b0;
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
